res_station: RTL

Integer reservation station at the receiving end of the issue-stage `rs_en` interface. It buffers up to DEPTH ALU instructions with their operand values or producer ROB tags, and captures missing operands from the CDB. Instructions whose operands are both ready are dispatched oldest-first, through a registered valid/ready output, to the integer ALU. `full_o` feeds back into the issue stall.

---
 rtl/res_station.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/res_station.sv
// Integer reservation station: buffers ALU instructions until both operands are
// available (directly at issue or captured from the CDB), then dispatches the
// oldest ready instruction through a registered valid/ready output stage.
module res_station #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     rs_en_i,
    input  logic [OP_W-1:0]          alu_op_i,
    input  logic [TAG_W-1:0]         rs_tag_i,
    input  logic [XLEN-1:0]          rs1_value_i,
    input  logic [XLEN-1:0]          rs2_value_i,
    input  logic                     rs1_rdy_i,
    input  logic                     rs2_rdy_i,
    input  logic [TAG_W-1:0]         rs1_q_i,
    input  logic [TAG_W-1:0]         rs2_q_i,
    input  logic                     cdb_valid_i,
    input  logic [TAG_W-1:0]         cdb_tag_i,
    input  logic [XLEN-1:0]          cdb_value_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ex_valid_o,
    input  logic                     ex_ready_i,
    output logic [OP_W-1:0]          ex_alu_op_o,
    output logic [XLEN-1:0]          ex_a_o,
    output logic [XLEN-1:0]          ex_b_o,
    output logic [TAG_W-1:0]         ex_tag_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Entry storage
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] r1_q, r1_d, r2_q, r2_d;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [OP_W-1:0]  op_d  [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [XLEN-1:0]  v1_q  [DEPTH];
    logic [XLEN-1:0]  v1_d  [DEPTH];
    logic [XLEN-1:0]  v2_q  [DEPTH];
    logic [XLEN-1:0]  v2_d  [DEPTH];
    logic [TAG_W-1:0] q1_q  [DEPTH];
    logic [TAG_W-1:0] q1_d  [DEPTH];
    logic [TAG_W-1:0] q2_q  [DEPTH];
    logic [TAG_W-1:0] q2_d  [DEPTH];
    // older_q[i][j] = 1 means entry i was allocated before entry j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    // Output stage
    logic             ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]  ex_op_q, ex_op_d;
    logic [XLEN-1:0]  ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [TAG_W-1:0] ex_tag_q, ex_tag_d;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] is_oldest;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc;
    logic             load;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             hit1, hit2;

    // Occupancy, free-slot search and oldest-ready selection from registered state
    always_comb begin
        full      = &valid_q;
        count     = '0;
        alloc_idx = '0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            count    = count + CNT_W'(valid_q[i]);
            ready[i] = valid_q[i] & r1_q[i] & r2_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            is_oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) is_oldest[i] = 1'b0;
            end
        end
        sel_found = |is_oldest;
        for (int i = 0; i < DEPTH; i++) begin
            if (is_oldest[i]) sel_idx = IDX_W'(i);
        end
        // A flush wins over both allocation and dispatch on the same edge
        alloc = rs_en_i && !full && !flush_i;
        load  = !flush_i && sel_found && (!ex_valid_q || ex_ready_i);
        hit1  = cdb_valid_i && !rs1_rdy_i && (rs1_q_i == cdb_tag_i);
        hit2  = cdb_valid_i && !rs2_rdy_i && (rs2_q_i == cdb_tag_i);
    end

    // Entry next-state: wakeup, free on dispatch, allocation, age update, flush
    always_comb begin
        valid_d = valid_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        op_d    = op_q;
        tag_d   = tag_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        older_d = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid_i && valid_q[i]) begin
                if (!r1_q[i] && (q1_q[i] == cdb_tag_i)) begin
                    v1_d[i] = cdb_value_i;
                    r1_d[i] = 1'b1;
                end
                if (!r2_q[i] && (q2_q[i] == cdb_tag_i)) begin
                    v2_d[i] = cdb_value_i;
                    r2_d[i] = 1'b1;
                end
            end
        end
        if (load) valid_d[sel_idx] = 1'b0;
        // The allocation target is free in registered state, so it never
        // collides with the entry being dispatched this cycle.
        if (alloc) begin
            valid_d[alloc_idx] = 1'b1;
            op_d[alloc_idx]    = alu_op_i;
            tag_d[alloc_idx]   = rs_tag_i;
            v1_d[alloc_idx]    = hit1 ? cdb_value_i : rs1_value_i;
            v2_d[alloc_idx]    = hit2 ? cdb_value_i : rs2_value_i;
            r1_d[alloc_idx]    = rs1_rdy_i | hit1;
            r2_d[alloc_idx]    = rs2_rdy_i | hit2;
            q1_d[alloc_idx]    = rs1_q_i;
            q2_d[alloc_idx]    = rs2_q_i;
            for (int j = 0; j < DEPTH; j++) begin
                older_d[alloc_idx][j] = 1'b0;
                older_d[j][alloc_idx] = (j != int'(alloc_idx));
            end
        end
        if (flush_i) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
        end
    end

    // Output register next-state: load when empty or consumed, else hold
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_tag_d   = ex_tag_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (load) begin
            ex_valid_d = 1'b1;
            ex_op_d    = op_q[sel_idx];
            ex_a_d     = v1_q[sel_idx];
            ex_b_d     = v2_q[sel_idx];
            ex_tag_d   = tag_q[sel_idx];
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= '0;
                tag_q[i]   <= '0;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
                q1_q[i]    <= '0;
                q2_q[i]    <= '0;
                older_q[i] <= '0;
            end
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_tag_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            q1_q       <= q1_d;
            q2_q       <= q2_d;
            older_q    <= older_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_tag_q   <= ex_tag_d;
        end
    end

    assign full_o      = full;
    assign count_o     = count;
    assign ex_valid_o  = ex_valid_q;
    assign ex_alu_op_o = ex_op_q;
    assign ex_a_o      = ex_a_q;
    assign ex_b_o      = ex_b_q;
    assign ex_tag_o    = ex_tag_q;
endmodule
